// File: rtl/axis_sc_pkt_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word fall-through, occupancy count and almost-full flag.
// Define AXIS_SC_PKT_FIFO_PACKET_MODE_EN for store-and-forward: beats are held until a whole packet (tlast) is stored.
module axis_sc_pkt_fifo #(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_DATA_DEPTH  = 16,
  parameter int C_ALMOST_FULL = 12,
  localparam int CW           = $clog2(C_DATA_DEPTH + 1)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [C_DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tlast,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [C_DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [CW-1:0]           count,
  output logic                    almost_full
);

  localparam int AW = $clog2(C_DATA_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(C_DATA_DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(C_ALMOST_FULL);

  logic [C_DATA_WIDTH:0] mem [C_DATA_DEPTH];
  logic [C_DATA_WIDTH:0] head;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty, wr_en, rd_en;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Ready is forced low while reset is asserted so no beat is taken during reset.
  assign in_tready   = aresetn && !full;
  assign wr_en       = in_tvalid && in_tready;
  assign rd_en       = out_tvalid && out_tready;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_C);

  assign head      = mem[rd_ptr_q];
  assign out_tdata = head[C_DATA_WIDTH-1:0];
  assign out_tlast = head[C_DATA_WIDTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (!wr_en && rd_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= {in_tlast, in_tdata};
  end

`ifdef AXIS_SC_PKT_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_in, pkt_out;

  assign pkt_in  = wr_en && in_tlast;
  assign pkt_out = rd_en && out_tlast;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_in && !pkt_out)      pkt_cnt_d = pkt_cnt_q + CW'(1);
    else if (!pkt_in && pkt_out) pkt_cnt_d = pkt_cnt_q - CW'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end

  // The full term lets a packet longer than the FIFO drain instead of deadlocking.
  assign out_tvalid = !empty && ((pkt_cnt_q != '0) || full);
`else
  assign out_tvalid = !empty;
`endif

endmodule

// File: tb/tb_axis_sc_pkt_fifo.sv
// Directed bench for axis_sc_pkt_fifo at default parameters (width 32, depth 16, almost-full 12).
// Packet-mode scenarios are compiled only when AXIS_SC_PKT_FIFO_PACKET_MODE_EN is defined.
module tb_axis_sc_pkt_fifo;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] in_tdata;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic [4:0]  count;
  logic        almost_full;

  int n_chk  = 0;
  int n_pass = 0;

  axis_sc_pkt_fifo #(
    .C_DATA_WIDTH (32),
    .C_DATA_DEPTH (16),
    .C_ALMOST_FULL(12)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn    = 1'b0;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
    tick();
    tick();
    check("rst_in_tready",   32'(in_tready),   32'd0);
    check("rst_out_tvalid",  32'(out_tvalid),  32'd0);
    check("rst_count",       32'(count),       32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    aresetn = 1'b1;
    #1;
    check("post_rst_in_tready", 32'(in_tready), 32'd1);

    // Basic write of 1..5 then read back
    for (int i = 1; i <= 5; i++) begin
      in_tdata  = 32'(i);
      in_tlast  = 1'b1;
      in_tvalid = 1'b1;
      tick();
      if (i == 1) begin
        check("t1_first_vld",  32'(out_tvalid), 32'd1);
        check("t1_first_data", out_tdata,       32'd1);
      end
    end
    in_tvalid = 1'b0;
    check("t1_count5", 32'(count), 32'd5);
    out_tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("t1_rd_vld",  32'(out_tvalid), 32'd1);
      check("t1_rd_data", out_tdata,       32'(i));
      tick();
    end
    out_tready = 1'b0;
    check("t1_count0", 32'(count),      32'd0);
    check("t1_vld0",   32'(out_tvalid), 32'd0);

    // Full boundary, almost_full threshold, held 17th beat
    for (int i = 0; i < 16; i++) begin
      in_tdata  = 32'h100 + 32'(i);
      in_tlast  = 1'b1;
      in_tvalid = 1'b1;
      tick();
      check("t2_count", 32'(count), 32'(i + 1));
      check("t2_afull", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      check("t2_ready", 32'(in_tready),   (i + 1 == 16) ? 32'd0 : 32'd1);
    end
    in_tdata = 32'h1FF;
    tick();
    check("t2_held_count", 32'(count),     32'd16);
    check("t2_held_ready", 32'(in_tready), 32'd0);
    check("t2_head",       out_tdata,      32'h100);
    out_tready = 1'b1;
    tick();
    out_tready = 1'b0;
    check("t2_ready_back", 32'(in_tready), 32'd1);
    check("t2_count15",    32'(count),     32'd15);
    tick();
    in_tvalid = 1'b0;
    check("t2_count_refill", 32'(count), 32'd16);
    out_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("t2_drain_data", out_tdata, (i == 16) ? 32'h1FF : 32'h100 + 32'(i));
      tick();
    end
    out_tready = 1'b0;
    check("t2_empty", 32'(count), 32'd0);

    // Continuous streaming across pointer wraps at occupancy 3
    for (int i = 0; i < 3; i++) begin
      in_tdata  = 32'h3000 + 32'(i);
      in_tlast  = 1'b1;
      in_tvalid = 1'b1;
      tick();
    end
    out_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_tdata = 32'h3003 + 32'(i);
      check("t3_vld",   32'(out_tvalid), 32'd1);
      check("t3_data",  out_tdata,       32'h3000 + 32'(i));
      check("t3_count", 32'(count),      32'd3);
      tick();
    end
    in_tvalid = 1'b0;
    for (int i = 100; i < 103; i++) begin
      check("t3_tail_data", out_tdata, 32'h3000 + 32'(i));
      tick();
    end
    out_tready = 1'b0;
    check("t3_empty", 32'(count), 32'd0);

`ifdef AXIS_SC_PKT_FIFO_PACKET_MODE_EN
    // Packet released only after its tlast beat is stored
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_tdata  = 32'h40 + 32'(i);
      in_tlast  = (i == 3);
      in_tvalid = 1'b1;
      check("t4_hold_vld", 32'(out_tvalid), 32'd0);
      tick();
    end
    in_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_vld",  32'(out_tvalid), 32'd1);
      check("t4_data", out_tdata,       32'h40 + 32'(i));
      check("t4_last", 32'(out_tlast),  (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    out_tready = 1'b0;
    check("t4_vld_end", 32'(out_tvalid), 32'd0);

    // Oversize packet escapes through the full term
    for (int i = 0; i < 16; i++) begin
      in_tdata  = 32'h500 + 32'(i);
      in_tlast  = 1'b0;
      in_tvalid = 1'b1;
      tick();
      if (i == 14) check("t5_vld_at15", 32'(out_tvalid), 32'd0);
    end
    in_tvalid = 1'b0;
    check("t5_vld_full", 32'(out_tvalid), 32'd1);
    for (int i = 16; i < 20; i++) begin
      out_tready = 1'b1;
      check("t5_esc_data", out_tdata,      32'h500 + 32'(i - 16));
      check("t5_esc_last", 32'(out_tlast), 32'd0);
      tick();
      out_tready = 1'b0;
      check("t5_vld_drop", 32'(out_tvalid), 32'd0);
      in_tdata  = 32'h500 + 32'(i);
      in_tlast  = (i == 19);
      in_tvalid = 1'b1;
      tick();
      in_tvalid = 1'b0;
    end
    out_tready = 1'b1;
    for (int i = 4; i < 20; i++) begin
      check("t5_vld",  32'(out_tvalid), 32'd1);
      check("t5_data", out_tdata,       32'h500 + 32'(i));
      check("t5_last", 32'(out_tlast),  (i == 19) ? 32'd1 : 32'd0);
      tick();
    end
    out_tready = 1'b0;
    check("t5_empty", 32'(count), 32'd0);
`endif

    // Reset with a partial packet stored
    for (int i = 0; i < 7; i++) begin
      in_tdata  = 32'h600 + 32'(i);
      in_tlast  = 1'b0;
      in_tvalid = 1'b1;
      tick();
    end
    in_tvalid = 1'b0;
    check("t6_count7", 32'(count), 32'd7);
    aresetn = 1'b0;
    #1;
    check("t6_rst_count", 32'(count),      32'd0);
    check("t6_rst_vld",   32'(out_tvalid), 32'd0);
    check("t6_rst_ready", 32'(in_tready),  32'd0);
    tick();
    aresetn   = 1'b1;
    in_tdata  = 32'hA5;
    in_tlast  = 1'b1;
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    check("t6_vld",  32'(out_tvalid), 32'd1);
    check("t6_data", out_tdata,       32'hA5);
    check("t6_last", 32'(out_tlast),  32'd1);
    out_tready = 1'b1;
    tick();
    out_tready = 1'b0;
    check("t6_count0", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
